// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the load-use hazard scoreboard: register-file
// geometry and the encoding of "late" (written back after Execute)
// instruction classes.
package hazard_scoreboard_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  // Classes of instruction whose result arrives after Execute.
  typedef enum logic [1:0] {
    LATE_NONE   = 2'b00,
    LATE_LOAD   = 2'b01,
    LATE_MULDIV = 2'b10
  } late_class_e;

  // Classify a decoded instruction; mul/div only counts when tracking is on.
  function automatic late_class_e classify_late(
    input logic load,
    input logic muldiv,
    input logic muldiv_en
  );
    late_class_e cls;
    if (load) begin
      cls = LATE_LOAD;
    end else if (muldiv && muldiv_en) begin
      cls = LATE_MULDIV;
    end else begin
      cls = LATE_NONE;
    end
    return cls;
  endfunction

  // True for any class whose destination must be tracked.
  function automatic logic is_late(input late_class_e cls);
    logic late;
    case (cls)
      LATE_LOAD, LATE_MULDIV: late = 1'b1;
      default:                late = 1'b0;
    endcase
    return late;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_counter.sv
// One per-register in-flight counter. Saturates at both ends; a retire
// request seen at zero is reported on err_o (a single-cycle pulse) and the
// count is held at zero. Simultaneous increment and decrement cancel.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  // Next count: saturating up/down, cancelling when both are requested.
  always_comb begin
    cnt_nxt_s = cnt_r;
    case ({inc_i, dec_i})
      2'b10: begin
        if (cnt_r != CNT_MAX) begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      2'b01: begin
        if (cnt_r != CNT_ZERO) begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end else begin
          cnt_nxt_s = CNT_ZERO;
        end
      end
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  assign cnt_o = cnt_r;
  assign err_o = dec_i & ~inc_i & (cnt_r == CNT_ZERO);

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use hazard scoreboard. Tracks destinations of late results (loads,
// and mul/div when the MULDIV_SB_EN macro is defined) from Execute until
// Writeback, and raises data_hazard_o when Decode reads one of them or
// when a new late write would overflow its register's counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 dec_valid_i,
  input  logic [REG_IDX_W-1:0] dec_rs1_i,
  input  logic [REG_IDX_W-1:0] dec_rs2_i,
  input  logic                 dec_rs1_used_i,
  input  logic                 dec_rs2_used_i,
  input  logic [REG_IDX_W-1:0] dec_rd_i,
  input  logic                 dec_load_i,
  input  logic                 dec_muldiv_i,
  input  logic                 stall_i,
  input  logic                 flush2dec_i,
  input  logic                 flush2exe_i,
  input  logic                 wb_valid_i,
  input  logic [REG_IDX_W-1:0] wb_rd_i,
  output logic                 data_hazard_o,
  output logic                 sb_busy_o,
  output logic                 sb_err_o
);

`ifdef MULDIV_SB_EN
  localparam logic MULDIV_EN = 1'b1;
`else
  localparam logic MULDIV_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0]     CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]     CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]     CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]     CNT_MAX_M1 = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [REG_IDX_W-1:0] REG_X0     = {REG_IDX_W{1'b0}};

  late_class_e                     dec_class_s;
  logic                            late_s;
  logic                            issue_s;
  logic                            exe_fire_s;
  logic                            exe_vld_r;
  logic [REG_IDX_W-1:0]            exe_rd_r;
  logic [NUM_REGS-1:0][CNT_W-1:0]  cnt_s;
  logic [NUM_REGS-1:1]             inc_s;
  logic [NUM_REGS-1:1]             dec_s;
  logic [NUM_REGS-1:1]             err_s;
  logic                            rs1_haz_s;
  logic                            rs2_haz_s;
  logic                            sat_haz_s;
  logic                            hazard_s;
  logic                            sb_busy_r;
  logic                            sb_err_r;

  // A register still has a pending late write once this cycle's retire is
  // accounted for; a same-cycle retire of the last one bypasses.
  function automatic logic pending(input logic [CNT_W-1:0] cnt, input logic retiring);
    return (cnt != CNT_ZERO) && !((cnt == CNT_ONE) && retiring);
  endfunction

  // Whether the retire port targets a given register this cycle.
  function automatic logic retiring_reg(input logic [REG_IDX_W-1:0] rs,
                                        input logic wb_vld,
                                        input logic [REG_IDX_W-1:0] wb_rd);
    return wb_vld && (wb_rd == rs) && (rs != REG_X0);
  endfunction

  assign dec_class_s = classify_late(dec_load_i, dec_muldiv_i, MULDIV_EN);
  assign late_s      = is_late(dec_class_s) && (dec_rd_i != REG_X0);
  assign issue_s     = dec_valid_i & ~hazard_s & ~stall_i & ~flush2dec_i;
  assign exe_fire_s  = ~stall_i & exe_vld_r & ~flush2exe_i;

  // Per-register increment (Execute slot leaving) and decrement (Writeback).
  always_comb begin
    inc_s = '0;
    dec_s = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      inc_s[i] = exe_fire_s && (exe_rd_r == REG_IDX_W'(i));
      dec_s[i] = wb_valid_i && (wb_rd_i == REG_IDX_W'(i));
    end
  end

  // In-flight counters; x0 is hard-wired to zero and never tracked.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    if (g == 0) begin : g_x0
      assign cnt_s[g] = CNT_ZERO;
    end else begin : g_cnt
      sb_counter #(
        .CNT_W (CNT_W)
      ) u_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (inc_s[g]),
        .dec_i  (dec_s[g]),
        .cnt_o  (cnt_s[g]),
        .err_o  (err_s[g])
      );
    end
  end

  // Source-operand and counter-saturation hazard detection.
  always_comb begin
    rs1_haz_s = 1'b0;
    rs2_haz_s = 1'b0;
    sat_haz_s = 1'b0;
    if (dec_rs1_used_i && (dec_rs1_i != REG_X0)) begin
      rs1_haz_s = (exe_vld_r && (exe_rd_r == dec_rs1_i)) ||
                  pending(cnt_s[dec_rs1_i], retiring_reg(dec_rs1_i, wb_valid_i, wb_rd_i));
    end else begin
      rs1_haz_s = 1'b0;
    end
    if (dec_rs2_used_i && (dec_rs2_i != REG_X0)) begin
      rs2_haz_s = (exe_vld_r && (exe_rd_r == dec_rs2_i)) ||
                  pending(cnt_s[dec_rs2_i], retiring_reg(dec_rs2_i, wb_valid_i, wb_rd_i));
    end else begin
      rs2_haz_s = 1'b0;
    end
    if (late_s) begin
      sat_haz_s = (cnt_s[dec_rd_i] == CNT_MAX) ||
                  ((cnt_s[dec_rd_i] == CNT_MAX_M1) && exe_vld_r && (exe_rd_r == dec_rd_i));
    end else begin
      sat_haz_s = 1'b0;
    end
    hazard_s = dec_valid_i & (rs1_haz_s | rs2_haz_s | sat_haz_s);
  end

  // Execute slot: frozen by stall, otherwise reloaded from Decode.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exe_vld_r <= 1'b0;
      exe_rd_r  <= REG_X0;
    end else if (!stall_i) begin
      exe_vld_r <= issue_s & late_s;
      exe_rd_r  <= dec_rd_i;
    end
  end

  // Registered busy indication and sticky retire-underflow error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sb_busy_r <= 1'b0;
      sb_err_r  <= 1'b0;
    end else begin
      sb_busy_r <= (|cnt_s) | exe_vld_r;
      sb_err_r  <= sb_err_r | (|err_s);
    end
  end

  assign data_hazard_o = hazard_s;
  assign sb_busy_o     = sb_busy_r;
  assign sb_err_o      = sb_err_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard. Expected values are pushed to
// a queue as each cycle's stimulus is driven and popped at the falling
// edge, where they are compared with the outputs and the watched counter.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       dec_valid_i;
  logic [4:0] dec_rs1_i, dec_rs2_i, dec_rd_i, wb_rd_i;
  logic       dec_rs1_used_i, dec_rs2_used_i, dec_load_i, dec_muldiv_i;
  logic       stall_i, flush2dec_i, flush2exe_i, wb_valid_i;
  logic       data_hazard_o, sb_busy_o, sb_err_o;

`ifdef MULDIV_SB_EN
  localparam logic MD = 1'b1;
`else
  localparam logic MD = 1'b0;
`endif

  typedef struct {
    string      name;
    logic       haz;
    logic       busy;
    logic       err;
    int         reg_idx;
    logic [1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  hazard_scoreboard #(.CNT_W(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .dec_valid_i(dec_valid_i),
    .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i),
    .dec_rs1_used_i(dec_rs1_used_i), .dec_rs2_used_i(dec_rs2_used_i),
    .dec_rd_i(dec_rd_i), .dec_load_i(dec_load_i), .dec_muldiv_i(dec_muldiv_i),
    .stall_i(stall_i), .flush2dec_i(flush2dec_i), .flush2exe_i(flush2exe_i),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
    .data_hazard_o(data_hazard_o), .sb_busy_o(sb_busy_o), .sb_err_o(sb_err_o)
  );

  always #5 clk = ~clk;

  task automatic idle();
    dec_valid_i = 1'b0; dec_rs1_i = 5'd0; dec_rs2_i = 5'd0; dec_rd_i = 5'd0;
    dec_rs1_used_i = 1'b0; dec_rs2_used_i = 1'b0; dec_load_i = 1'b0; dec_muldiv_i = 1'b0;
    stall_i = 1'b0; flush2dec_i = 1'b0; flush2exe_i = 1'b0; wb_valid_i = 1'b0; wb_rd_i = 5'd0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic ld, input logic md);
    dec_valid_i = 1'b1; dec_rd_i = rd; dec_load_i = ld; dec_muldiv_i = md;
  endtask

  task automatic consume(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    dec_valid_i = 1'b1; dec_rs1_i = rs1; dec_rs2_i = rs2; dec_rd_i = rd;
    dec_rs1_used_i = 1'b1; dec_rs2_used_i = 1'b1;
  endtask

  task automatic retire(input logic [4:0] rd);
    wb_valid_i = 1'b1; wb_rd_i = rd;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    exp_t e;
    idle(); rst_ni = 1'b0;
    consume(5'd5, 5'd6, 5'd7);
    exp_q.push_back('{"reset", 1'b0, 1'b0, 1'b0, 5, 2'd0});
    @(negedge clk); e = exp_q.pop_front();
    checks += 4;
    if (data_hazard_o !== e.haz) begin errors++; $display("FAIL %s hazard got=%b want=%b", e.name, data_hazard_o, e.haz); end
    if (sb_busy_o !== e.busy) begin errors++; $display("FAIL %s busy got=%b want=%b", e.name, sb_busy_o, e.busy); end
    if (sb_err_o !== e.err) begin errors++; $display("FAIL %s err got=%b want=%b", e.name, sb_err_o, e.err); end
    if (dut.cnt_s[e.reg_idx] !== e.cnt) begin errors++; $display("FAIL %s cnt got=%0d want=%0d", e.name, dut.cnt_s[e.reg_idx], e.cnt); end
    tick(); rst_ni = 1'b1; idle(); tick();
  endtask

  task automatic test_load_use();
    logic h, b; logic [1:0] cn; exp_t e;
    for (int c = 0; c < 6; c++) begin
      idle();
      case (c)
        0: begin issue(5'd5, 1'b1, 1'b0); h = 1'b0; b = 1'b0; cn = 2'd0; end
        1: begin consume(5'd5, 5'd1, 5'd6); h = 1'b1; b = 1'b0; cn = 2'd0; end
        2: begin consume(5'd5, 5'd1, 5'd6); h = 1'b1; b = 1'b1; cn = 2'd1; end
        3: begin consume(5'd5, 5'd1, 5'd6); retire(5'd5); h = 1'b0; b = 1'b1; cn = 2'd1; end
        4: begin h = 1'b0; b = 1'b1; cn = 2'd0; end
        default: begin h = 1'b0; b = 1'b0; cn = 2'd0; end
      endcase
      exp_q.push_back('{$sformatf("load_use[%0d]", c), h, b, 1'b0, 5, cn});
      @(negedge clk); e = exp_q.pop_front();
      checks += 4;
      if (data_hazard_o !== e.haz) begin errors++; $display("FAIL %s hazard got=%b want=%b", e.name, data_hazard_o, e.haz); end
      if (sb_busy_o !== e.busy) begin errors++; $display("FAIL %s busy got=%b want=%b", e.name, sb_busy_o, e.busy); end
      if (sb_err_o !== e.err) begin errors++; $display("FAIL %s err got=%b want=%b", e.name, sb_err_o, e.err); end
      if (dut.cnt_s[e.reg_idx] !== e.cnt) begin errors++; $display("FAIL %s cnt got=%0d want=%0d", e.name, dut.cnt_s[e.reg_idx], e.cnt); end
      tick();
    end
  endtask

  task automatic test_flush_exe();
    logic h, b; exp_t e;
    for (int c = 0; c < 5; c++) begin
      idle();
      case (c)
        0: begin issue(5'd7, 1'b1, 1'b0); h = 1'b0; b = 1'b0; end
        1: begin flush2exe_i = 1'b1; flush2dec_i = 1'b1; h = 1'b0; b = 1'b0; end
        2: begin consume(5'd7, 5'd0, 5'd8); h = 1'b0; b = 1'b1; end
        default: begin h = 1'b0; b = 1'b0; end
      endcase
      exp_q.push_back('{$sformatf("flush_exe[%0d]", c), h, b, 1'b0, 7, 2'd0});
      @(negedge clk); e = exp_q.pop_front();
      checks += 4;
      if (data_hazard_o !== e.haz) begin errors++; $display("FAIL %s hazard got=%b want=%b", e.name, data_hazard_o, e.haz); end
      if (sb_busy_o !== e.busy) begin errors++; $display("FAIL %s busy got=%b want=%b", e.name, sb_busy_o, e.busy); end
      if (sb_err_o !== e.err) begin errors++; $display("FAIL %s err got=%b want=%b", e.name, sb_err_o, e.err); end
      if (dut.cnt_s[e.reg_idx] !== e.cnt) begin errors++; $display("FAIL %s cnt got=%0d want=%0d", e.name, dut.cnt_s[e.reg_idx], e.cnt); end
      tick();
    end
  endtask

  task automatic test_saturation();
    logic h, b; logic [1:0] cn; exp_t e;
    for (int c = 0; c < 11; c++) begin
      idle();
      case (c)
        0: begin issue(5'd9, 1'b1, 1'b0); h = 1'b0; b = 1'b0; cn = 2'd0; end
        1: begin issue(5'd9, 1'b1, 1'b0); h = 1'b0; b = 1'b0; cn = 2'd0; end
        2: begin issue(5'd9, 1'b1, 1'b0); h = 1'b0; b = 1'b1; cn = 2'd1; end
        3: begin issue(5'd9, 1'b1, 1'b0); h = 1'b1; b = 1'b1; cn = 2'd2; end
        4: begin issue(5'd9, 1'b1, 1'b0); retire(5'd9); h = 1'b1; b = 1'b1; cn = 2'd3; end
        5: begin issue(5'd9, 1'b1, 1'b0); h = 1'b0; b = 1'b1; cn = 2'd2; end
        6: begin retire(5'd9); h = 1'b0; b = 1'b1; cn = 2'd2; end
        7: begin retire(5'd9); h = 1'b0; b = 1'b1; cn = 2'd2; end
        8: begin retire(5'd9); h = 1'b0; b = 1'b1; cn = 2'd1; end
        9: begin h = 1'b0; b = 1'b1; cn = 2'd0; end
        default: begin h = 1'b0; b = 1'b0; cn = 2'd0; end
      endcase
      exp_q.push_back('{$sformatf("saturate[%0d]", c), h, b, 1'b0, 9, cn});
      @(negedge clk); e = exp_q.pop_front();
      checks += 4;
      if (data_hazard_o !== e.haz) begin errors++; $display("FAIL %s hazard got=%b want=%b", e.name, data_hazard_o, e.haz); end
      if (sb_busy_o !== e.busy) begin errors++; $display("FAIL %s busy got=%b want=%b", e.name, sb_busy_o, e.busy); end
      if (sb_err_o !== e.err) begin errors++; $display("FAIL %s err got=%b want=%b", e.name, sb_err_o, e.err); end
      if (dut.cnt_s[e.reg_idx] !== e.cnt) begin errors++; $display("FAIL %s cnt got=%0d want=%0d", e.name, dut.cnt_s[e.reg_idx], e.cnt); end
      tick();
    end
  endtask

  task automatic test_stall();
    logic h, b; logic [1:0] cn; exp_t e;
    for (int c = 0; c < 7; c++) begin
      idle();
      case (c)
        0: begin issue(5'd10, 1'b1, 1'b0); h = 1'b0; b = 1'b0; cn = 2'd0; end
        1: begin stall_i = 1'b1; consume(5'd10, 5'd2, 5'd11); h = 1'b1; b = 1'b0; cn = 2'd0; end
        2: begin stall_i = 1'b1; flush2exe_i = 1'b1; consume(5'd10, 5'd2, 5'd11); h = 1'b1; b = 1'b1; cn = 2'd0; end
        3: begin h = 1'b0; b = 1'b1; cn = 2'd0; end
        4: begin stall_i = 1'b1; retire(5'd10); consume(5'd2, 5'd10, 5'd11); h = 1'b0; b = 1'b1; cn = 2'd1; end
        5: begin h = 1'b0; b = 1'b1; cn = 2'd0; end
        default: begin h = 1'b0; b = 1'b0; cn = 2'd0; end
      endcase
      exp_q.push_back('{$sformatf("stall[%0d]", c), h, b, 1'b0, 10, cn});
      @(negedge clk); e = exp_q.pop_front();
      checks += 4;
      if (data_hazard_o !== e.haz) begin errors++; $display("FAIL %s hazard got=%b want=%b", e.name, data_hazard_o, e.haz); end
      if (sb_busy_o !== e.busy) begin errors++; $display("FAIL %s busy got=%b want=%b", e.name, sb_busy_o, e.busy); end
      if (sb_err_o !== e.err) begin errors++; $display("FAIL %s err got=%b want=%b", e.name, sb_err_o, e.err); end
      if (dut.cnt_s[e.reg_idx] !== e.cnt) begin errors++; $display("FAIL %s cnt got=%0d want=%0d", e.name, dut.cnt_s[e.reg_idx], e.cnt); end
      tick();
    end
  endtask

  task automatic test_muldiv();
    logic h, b; logic [1:0] cn; exp_t e;
    for (int c = 0; c < 5; c++) begin
      idle();
      case (c)
        0: begin issue(5'd4, 1'b0, 1'b1); h = 1'b0; b = 1'b0; cn = 2'd0; end
        1: begin consume(5'd4, 5'd0, 5'd12); h = MD; b = 1'b0; cn = 2'd0; end
        2: begin consume(5'd4, 5'd0, 5'd12); if (MD) retire(5'd4); h = 1'b0; b = MD; cn = {1'b0, MD}; end
        3: begin h = 1'b0; b = MD; cn = 2'd0; end
        default: begin h = 1'b0; b = 1'b0; cn = 2'd0; end
      endcase
      exp_q.push_back('{$sformatf("muldiv[%0d]", c), h, b, 1'b0, 4, cn});
      @(negedge clk); e = exp_q.pop_front();
      checks += 4;
      if (data_hazard_o !== e.haz) begin errors++; $display("FAIL %s hazard got=%b want=%b", e.name, data_hazard_o, e.haz); end
      if (sb_busy_o !== e.busy) begin errors++; $display("FAIL %s busy got=%b want=%b", e.name, sb_busy_o, e.busy); end
      if (sb_err_o !== e.err) begin errors++; $display("FAIL %s err got=%b want=%b", e.name, sb_err_o, e.err); end
      if (dut.cnt_s[e.reg_idx] !== e.cnt) begin errors++; $display("FAIL %s cnt got=%0d want=%0d", e.name, dut.cnt_s[e.reg_idx], e.cnt); end
      tick();
    end
  endtask

  task automatic test_retire_error();
    logic er; exp_t e;
    for (int c = 0; c < 3; c++) begin
      idle();
      if (c == 0) begin retire(5'd3); er = 1'b0; end else begin er = 1'b1; end
      exp_q.push_back('{$sformatf("retire_err[%0d]", c), 1'b0, 1'b0, er, 3, 2'd0});
      @(negedge clk); e = exp_q.pop_front();
      checks += 4;
      if (data_hazard_o !== e.haz) begin errors++; $display("FAIL %s hazard got=%b want=%b", e.name, data_hazard_o, e.haz); end
      if (sb_busy_o !== e.busy) begin errors++; $display("FAIL %s busy got=%b want=%b", e.name, sb_busy_o, e.busy); end
      if (sb_err_o !== e.err) begin errors++; $display("FAIL %s err got=%b want=%b", e.name, sb_err_o, e.err); end
      if (dut.cnt_s[e.reg_idx] !== e.cnt) begin errors++; $display("FAIL %s cnt got=%0d want=%0d", e.name, dut.cnt_s[e.reg_idx], e.cnt); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic b; logic [1:0] cn; exp_t e;
    for (int c = 0; c < 4; c++) begin
      idle();
      case (c)
        0: begin issue(5'd11, 1'b1, 1'b0); b = 1'b0; cn = 2'd0; end
        1: begin issue(5'd12, 1'b1, 1'b0); b = 1'b0; cn = 2'd0; end
        2: begin b = 1'b1; cn = 2'd1; end
        default: begin consume(5'd11, 5'd12, 5'd13); b = 1'b1; cn = 2'd1; end
      endcase
      exp_q.push_back('{$sformatf("pre_reset[%0d]", c), (c == 3), b, 1'b1, 11, cn});
      @(negedge clk); e = exp_q.pop_front();
      checks += 4;
      if (data_hazard_o !== e.haz) begin errors++; $display("FAIL %s hazard got=%b want=%b", e.name, data_hazard_o, e.haz); end
      if (sb_busy_o !== e.busy) begin errors++; $display("FAIL %s busy got=%b want=%b", e.name, sb_busy_o, e.busy); end
      if (sb_err_o !== e.err) begin errors++; $display("FAIL %s err got=%b want=%b", e.name, sb_err_o, e.err); end
      if (dut.cnt_s[e.reg_idx] !== e.cnt) begin errors++; $display("FAIL %s cnt got=%0d want=%0d", e.name, dut.cnt_s[e.reg_idx], e.cnt); end
      if (c < 3) tick();
    end
    // Reset asserted between clock edges must clear everything at once.
    #1 rst_ni = 1'b0;
    #1;
    exp_q.push_back('{"async_reset", 1'b0, 1'b0, 1'b0, 11, 2'd0});
    e = exp_q.pop_front();
    checks += 4;
    if (data_hazard_o !== e.haz) begin errors++; $display("FAIL %s hazard got=%b want=%b", e.name, data_hazard_o, e.haz); end
    if (sb_busy_o !== e.busy) begin errors++; $display("FAIL %s busy got=%b want=%b", e.name, sb_busy_o, e.busy); end
    if (sb_err_o !== e.err) begin errors++; $display("FAIL %s err got=%b want=%b", e.name, sb_err_o, e.err); end
    if (dut.cnt_s[e.reg_idx] !== e.cnt) begin errors++; $display("FAIL %s cnt got=%0d want=%0d", e.name, dut.cnt_s[e.reg_idx], e.cnt); end
    tick();
    rst_ni = 1'b1; idle();
    consume(5'd12, 5'd11, 5'd13);
    exp_q.push_back('{"post_reset", 1'b0, 1'b0, 1'b0, 12, 2'd0});
    @(negedge clk); e = exp_q.pop_front();
    checks += 4;
    if (data_hazard_o !== e.haz) begin errors++; $display("FAIL %s hazard got=%b want=%b", e.name, data_hazard_o, e.haz); end
    if (sb_busy_o !== e.busy) begin errors++; $display("FAIL %s busy got=%b want=%b", e.name, sb_busy_o, e.busy); end
    if (sb_err_o !== e.err) begin errors++; $display("FAIL %s err got=%b want=%b", e.name, sb_err_o, e.err); end
    if (dut.cnt_s[e.reg_idx] !== e.cnt) begin errors++; $display("FAIL %s cnt got=%0d want=%0d", e.name, dut.cnt_s[e.reg_idx], e.cnt); end
    tick();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_flush_exe();
    test_saturation();
    test_stall();
    test_muldiv();
    test_retire_error();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
